simmem_release_scheduler: RTL and testbench
===========================================

# simmem_release_scheduler

- Parametrised successor to the per-ID release-enable generator of the simulated memory controller.
- Observes AXI address, write-data and response handshakes on two channels: channel 0 is read data, channel 1 is write response.
- Holds a slot for every outstanding transaction and counts down a per-transaction delay.
- Asserts per-ID release enables to the response banks once a transaction's simulated latency has elapsed. Supports read bursts, bounded slot pools and optional write-data gating.

## Interface
- `IDWidth`, 4: AXI ID width; release vectors are 2**IDWidth wide.
- `CounterWidth`, 8: delay counter width.
- `BurstLenWidth`, 8: AXI len field width.
- `ReadSlots`, 8: read slot pool depth (≥2).
- `WriteSlots`, 8: write slot pool depth (≥2).

Ports:
- `clk_i`  in  1  sole clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `rd_addr_valid_i` / `rd_addr_ready_i`  in  1 each  read address handshake.
- `rd_addr_id_i`  in  IDWidth  read address ID.
- `rd_addr_len_i`  in  BurstLenWidth  read burst length minus one.
- `wr_addr_valid_i` / `wr_addr_ready_i`  in  1 each  write address handshake.
- `wr_addr_id_i`  in  IDWidth  write address ID.
- `wr_data_valid_i` / `wr_data_ready_i` / `wr_data_last_i`  in  1 each  write data beat and last flag.
- `rd_data_valid_i` / `rd_data_ready_i`  in  1 each  read data beat handshake.
- `rd_data_id_i`  in  IDWidth  read data beat ID.
- `wr_resp_valid_i` / `wr_resp_ready_i`  in  1 each  write response handshake.
- `wr_resp_id_i`  in  IDWidth  write response ID.
- `rd_delay_i`, `wr_delay_i`  in  CounterWidth each  delay, sampled at allocation.
- `rd_slot_avail_o`, `wr_slot_avail_o`  out  1 each  at least one FREE slot; upstream must hold ready low when this is 0.
- `release_en_o`  out  [1:0][2**IDWidth-1:0]  `[0][id]` read data due, `[1][id]` write response due.
- `error_o`  out  1  sticky protocol error.

## Operation
- Slot states are FREE, WAIT_DATA (write pool only, with the macro), COUNTING and DONE.
- DONE is the COUNTING state with counter == 0; it is not a separate encoding.
- **Allocation**
  - Triggered by a handshake (valid & ready).
  - Takes the lowest-index FREE slot.
  - Loads id and counter = delay input.
  - Read slots also load beats = len+1, width BurstLenWidth+1, so len=255 gives 256.
  - If no slot is FREE, the handshake is dropped and `error_o` is set.
- **Countdown:** each cycle, a COUNTING slot with counter > 0 decrements by 1; the counter saturates at 0.
- **Release enable:** `release_en_o[c][i]` = OR over pool c of (slot is DONE and slot id == i).
- **Read beat**
  - On each read data handshake, select the lowest-index DONE read slot whose id matches.
  - Decrement its beats; when beats reaches 0 the slot goes FREE at the same edge.
- **Write response**
  - On a write response handshake, the lowest-index DONE write slot whose id matches goes FREE.
- **Unmatched response:** if no DONE slot matches a response handshake, the handshake is ignored and `error_o` is set.
- **Simultaneous events**
  - Allocation and free in the same cycle are both performed.
  - A slot freed in cycle T is not allocatable until T+1, because the FREE search uses registered state.
  - Read and write pools are fully independent.
- **Reset:** asserting `rst_ni` at any time, including mid-operation, forces:
  - all slots FREE;
  - `release_en_o` = 0;
  - both avail outputs = 1;
  - `error_o` = 0;
  - order FIFO empty and credits = 0.
- `error_o` clears only on reset.

## Timing
- All outputs are decoded from registered state only; there is no combinational input-to-output path.
- For an allocation handshake in cycle T with delay d, the release enable is high from cycle T+1+d. With d=0 it is high in T+1.
- Release stays high until the freeing handshake; it drops in the cycle after that edge unless another DONE slot has the same id.
- `rd_slot_avail_o` / `wr_slot_avail_o` update one cycle after the allocation or free that changes them.

## Configuration
- Macro: `SIMMEM_RELEASER_WDATA_GATE_EN`.
- **Defined: write countdown is gated on write data.**
  - A write allocation enters WAIT_DATA and its slot index is pushed into an order FIFO of depth WriteSlots.
  - Each write data handshake with `wr_data_last_i`=1 moves the oldest WAIT_DATA slot to COUNTING with its stored delay.
  - A last beat arriving while the FIFO is empty increments a credit counter (saturating at WriteSlots; overflow sets `error_o`).
  - An allocation while credit > 0 goes straight to COUNTING and decrements the credit.
  - An allocation in the same cycle as a last beat, with an empty FIFO and zero credit, goes straight to COUNTING.
  - Release for the gated case is T'+1+d, where T' is the cycle of the last beat.
- **Undefined:** write slots enter COUNTING at allocation, and write data inputs are ignored.

## Test plan
- Read alloc: id=3, len=0, rd_delay=5 in cycle 10 → `release_en_o[0][3]` is 0 through cycle 15, 1 at cycle 16; rd data handshake id=3 at cycle 18 → 0 at 19, `rd_slot_avail_o` stays 1.
- Read burst: len=3, delay=0 → enable high from the next cycle and through 4 beat handshakes; slot FREE after the 4th beat; `error_o`=0.
- Pool full: 8 write allocs with delay=200, then a 9th handshake → `wr_slot_avail_o`=0 after the 8th, and the 9th sets `error_o`=1 with no new slot.
- Two read slots with id=1 and delays 2 and 6 → enable high continuously from first expiry; after one handshake it stays high once the second is DONE; it drops only after the second handshake.
- Macro defined: write alloc with delay=1 in cycle 5, wlast in cycle 20 → `release_en_o[1][id]` rises at cycle 22. Wlast before alloc → alloc goes COUNTING immediately.
- Reset asserted mid-countdown with 3 slots busy → all outputs return to reset values asynchronously; first allocation after release uses slot 0.

Source files
------------

// File: rtl/simmem_release_scheduler.sv
// Per-ID release-enable scheduler for the simulated memory controller (read data / write response).
// Optional feature macro SIMMEM_RELEASER_WDATA_GATE_EN: write countdown starts only after the last write-data beat.
module simmem_release_scheduler #(
    parameter int unsigned IDWidth       = 4,
    parameter int unsigned CounterWidth  = 8,
    parameter int unsigned BurstLenWidth = 8,
    parameter int unsigned ReadSlots     = 8,
    parameter int unsigned WriteSlots    = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                rd_addr_valid_i,
    input  logic                                rd_addr_ready_i,
    input  logic [IDWidth-1:0]                  rd_addr_id_i,
    input  logic [BurstLenWidth-1:0]            rd_addr_len_i,
    input  logic                                wr_addr_valid_i,
    input  logic                                wr_addr_ready_i,
    input  logic [IDWidth-1:0]                  wr_addr_id_i,
    input  logic                                wr_data_valid_i,
    input  logic                                wr_data_ready_i,
    input  logic                                wr_data_last_i,
    input  logic                                rd_data_valid_i,
    input  logic                                rd_data_ready_i,
    input  logic [IDWidth-1:0]                  rd_data_id_i,
    input  logic                                wr_resp_valid_i,
    input  logic                                wr_resp_ready_i,
    input  logic [IDWidth-1:0]                  wr_resp_id_i,
    input  logic [CounterWidth-1:0]             rd_delay_i,
    input  logic [CounterWidth-1:0]             wr_delay_i,
    output logic                                rd_slot_avail_o,
    output logic                                wr_slot_avail_o,
    output logic [1:0][2**IDWidth-1:0]          release_en_o,
    output logic                                error_o
);
    localparam int unsigned NumIds  = 2 ** IDWidth;
    localparam int unsigned RdIdxW  = $clog2(ReadSlots);
    localparam int unsigned WrIdxW  = $clog2(WriteSlots);
    localparam int unsigned BeatW   = BurstLenWidth + 1;
    localparam int unsigned CreditW = $clog2(WriteSlots + 1);

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_WAIT_DATA = 2'd1,
        SLOT_COUNTING  = 2'd2
    } slot_state_e;

    // DONE is a COUNTING slot whose counter has reached zero.
    function automatic logic slot_done(input slot_state_e st, input logic [CounterWidth-1:0] cnt);
        return (st == SLOT_COUNTING) && (cnt == CounterWidth'(0));
    endfunction

    slot_state_e             rd_state_q [ReadSlots];
    slot_state_e             rd_state_d [ReadSlots];
    logic [IDWidth-1:0]      rd_id_q    [ReadSlots];
    logic [IDWidth-1:0]      rd_id_d    [ReadSlots];
    logic [CounterWidth-1:0] rd_cnt_q   [ReadSlots];
    logic [CounterWidth-1:0] rd_cnt_d   [ReadSlots];
    logic [BeatW-1:0]        rd_beats_q [ReadSlots];
    logic [BeatW-1:0]        rd_beats_d [ReadSlots];

    slot_state_e             wr_state_q [WriteSlots];
    slot_state_e             wr_state_d [WriteSlots];
    logic [IDWidth-1:0]      wr_id_q    [WriteSlots];
    logic [IDWidth-1:0]      wr_id_d    [WriteSlots];
    logic [CounterWidth-1:0] wr_cnt_q   [WriteSlots];
    logic [CounterWidth-1:0] wr_cnt_d   [WriteSlots];

    logic [1:0][NumIds-1:0]  release_q, release_d;
    logic                    rd_avail_q, rd_avail_d;
    logic                    wr_avail_q, wr_avail_d;
    logic                    error_q, error_d;

    logic                    rd_alloc_hs_s, rd_beat_hs_s, rd_alloc_ok_s, rd_beat_ok_s, rd_err_s;
    logic                    rd_free_found_s, rd_done_found_s;
    logic [RdIdxW-1:0]       rd_free_idx_s, rd_done_idx_s;
    logic                    wr_alloc_hs_s, wr_resp_hs_s, wr_alloc_ok_s, wr_resp_ok_s, wr_err_s;
    logic                    wr_free_found_s, wr_done_found_s;
    logic [WrIdxW-1:0]       wr_free_idx_s, wr_done_idx_s;
    logic                    wr_pop_s, wr_alloc_direct_s, wr_gate_err_s;
    logic [WrIdxW-1:0]       wr_fifo_head_s;

    // Read pool: lowest-index searches over registered state, then per-slot update.
    always_comb begin
        rd_state_d      = rd_state_q;
        rd_id_d         = rd_id_q;
        rd_cnt_d        = rd_cnt_q;
        rd_beats_d      = rd_beats_q;
        rd_alloc_hs_s   = rd_addr_valid_i & rd_addr_ready_i;
        rd_beat_hs_s    = rd_data_valid_i & rd_data_ready_i;
        rd_free_found_s = 1'b0;
        rd_free_idx_s   = '0;
        rd_done_found_s = 1'b0;
        rd_done_idx_s   = '0;
        for (int i = 0; i < ReadSlots; i++) begin
            rd_free_idx_s   = (!rd_free_found_s && rd_state_q[i] == SLOT_FREE) ? RdIdxW'(i) : rd_free_idx_s;
            rd_free_found_s = rd_free_found_s | (rd_state_q[i] == SLOT_FREE);
            rd_done_idx_s   = (!rd_done_found_s && slot_done(rd_state_q[i], rd_cnt_q[i]) &&
                               rd_id_q[i] == rd_data_id_i) ? RdIdxW'(i) : rd_done_idx_s;
            rd_done_found_s = rd_done_found_s |
                              (slot_done(rd_state_q[i], rd_cnt_q[i]) && rd_id_q[i] == rd_data_id_i);
        end
        rd_alloc_ok_s = rd_alloc_hs_s & rd_free_found_s;
        rd_beat_ok_s  = rd_beat_hs_s & rd_done_found_s;
        rd_err_s      = (rd_alloc_hs_s & ~rd_free_found_s) | (rd_beat_hs_s & ~rd_done_found_s);
        for (int i = 0; i < ReadSlots; i++) begin
            if (rd_alloc_ok_s && rd_free_idx_s == RdIdxW'(i)) begin
                rd_state_d[i] = SLOT_COUNTING;
                rd_id_d[i]    = rd_addr_id_i;
                rd_cnt_d[i]   = rd_delay_i;
                rd_beats_d[i] = BeatW'(rd_addr_len_i) + BeatW'(1);
            end else if (rd_beat_ok_s && rd_done_idx_s == RdIdxW'(i)) begin
                rd_beats_d[i] = rd_beats_q[i] - BeatW'(1);
                rd_state_d[i] = (rd_beats_q[i] == BeatW'(1)) ? SLOT_FREE : SLOT_COUNTING;
            end else if (rd_state_q[i] == SLOT_COUNTING && rd_cnt_q[i] != CounterWidth'(0)) begin
                rd_cnt_d[i] = rd_cnt_q[i] - CounterWidth'(1);
            end else begin
                rd_cnt_d[i] = rd_cnt_q[i];
            end
        end
    end

    // Write pool: same structure; allocation may park a slot in WAIT_DATA when gating is built in.
    always_comb begin
        wr_state_d      = wr_state_q;
        wr_id_d         = wr_id_q;
        wr_cnt_d        = wr_cnt_q;
        wr_alloc_hs_s   = wr_addr_valid_i & wr_addr_ready_i;
        wr_resp_hs_s    = wr_resp_valid_i & wr_resp_ready_i;
        wr_free_found_s = 1'b0;
        wr_free_idx_s   = '0;
        wr_done_found_s = 1'b0;
        wr_done_idx_s   = '0;
        for (int i = 0; i < WriteSlots; i++) begin
            wr_free_idx_s   = (!wr_free_found_s && wr_state_q[i] == SLOT_FREE) ? WrIdxW'(i) : wr_free_idx_s;
            wr_free_found_s = wr_free_found_s | (wr_state_q[i] == SLOT_FREE);
            wr_done_idx_s   = (!wr_done_found_s && slot_done(wr_state_q[i], wr_cnt_q[i]) &&
                               wr_id_q[i] == wr_resp_id_i) ? WrIdxW'(i) : wr_done_idx_s;
            wr_done_found_s = wr_done_found_s |
                              (slot_done(wr_state_q[i], wr_cnt_q[i]) && wr_id_q[i] == wr_resp_id_i);
        end
        wr_alloc_ok_s = wr_alloc_hs_s & wr_free_found_s;
        wr_resp_ok_s  = wr_resp_hs_s & wr_done_found_s;
        wr_err_s      = (wr_alloc_hs_s & ~wr_free_found_s) | (wr_resp_hs_s & ~wr_done_found_s);
        for (int i = 0; i < WriteSlots; i++) begin
            if (wr_alloc_ok_s && wr_free_idx_s == WrIdxW'(i)) begin
                wr_state_d[i] = wr_alloc_direct_s ? SLOT_COUNTING : SLOT_WAIT_DATA;
                wr_id_d[i]    = wr_addr_id_i;
                wr_cnt_d[i]   = wr_delay_i;
            end else if (wr_resp_ok_s && wr_done_idx_s == WrIdxW'(i)) begin
                wr_state_d[i] = SLOT_FREE;
            end else if (wr_pop_s && wr_fifo_head_s == WrIdxW'(i)) begin
                wr_state_d[i] = SLOT_COUNTING;
            end else if (wr_state_q[i] == SLOT_COUNTING && wr_cnt_q[i] != CounterWidth'(0)) begin
                wr_cnt_d[i] = wr_cnt_q[i] - CounterWidth'(1);
            end else begin
                wr_cnt_d[i] = wr_cnt_q[i];
            end
        end
    end

`ifdef SIMMEM_RELEASER_WDATA_GATE_EN
    logic [WrIdxW-1:0]  fifo_mem_q [WriteSlots];
    logic [WrIdxW-1:0]  fifo_rd_ptr_q, fifo_rd_ptr_d, fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [CreditW-1:0] fifo_cnt_q, fifo_cnt_d, credit_q, credit_d;
    logic               wlast_hs_s, wlast_unmatched_s, fifo_push_s;

    function automatic logic [WrIdxW-1:0] ptr_inc(input logic [WrIdxW-1:0] p);
        return (p == WrIdxW'(WriteSlots - 1)) ? WrIdxW'(0) : p + WrIdxW'(1);
    endfunction

    // Order FIFO pairs last beats with waiting slots; early last beats become credits.
    always_comb begin
        wlast_hs_s        = wr_data_valid_i & wr_data_ready_i & wr_data_last_i;
        wr_pop_s          = wlast_hs_s & (fifo_cnt_q != CreditW'(0));
        wlast_unmatched_s = wlast_hs_s & (fifo_cnt_q == CreditW'(0));
        wr_fifo_head_s    = fifo_mem_q[fifo_rd_ptr_q];
        wr_alloc_direct_s = wlast_unmatched_s | (credit_q != CreditW'(0));
        fifo_push_s       = wr_alloc_ok_s & ~wr_alloc_direct_s;
        wr_gate_err_s     = 1'b0;
        credit_d          = credit_q;
        if (wr_alloc_ok_s) begin
            credit_d = (!wlast_unmatched_s && credit_q != CreditW'(0)) ? credit_q - CreditW'(1) : credit_q;
        end else if (wlast_unmatched_s) begin
            if (credit_q == CreditW'(WriteSlots)) begin
                wr_gate_err_s = 1'b1;
            end else begin
                credit_d = credit_q + CreditW'(1);
            end
        end else begin
            credit_d = credit_q;
        end
        fifo_wr_ptr_d = fifo_push_s ? ptr_inc(fifo_wr_ptr_q) : fifo_wr_ptr_q;
        fifo_rd_ptr_d = wr_pop_s ? ptr_inc(fifo_rd_ptr_q) : fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q + CreditW'(fifo_push_s) - CreditW'(wr_pop_s);
    end

    // Order FIFO storage, pointers and credit counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WriteSlots; i++) begin
                fifo_mem_q[i] <= '0;
            end
            fifo_rd_ptr_q <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_cnt_q    <= '0;
            credit_q      <= '0;
        end else begin
            if (fifo_push_s) begin
                fifo_mem_q[fifo_wr_ptr_q] <= wr_free_idx_s;
            end
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            credit_q      <= credit_d;
        end
    end
`else
    logic unused_wdata_s;
    assign unused_wdata_s    = wr_data_valid_i ^ wr_data_ready_i ^ wr_data_last_i;
    assign wr_pop_s          = 1'b0;
    assign wr_alloc_direct_s = 1'b1;
    assign wr_gate_err_s     = 1'b0;
    assign wr_fifo_head_s    = '0;
`endif

    // Output decode from next state so the registered outputs track slot state exactly.
    always_comb begin
        release_d  = '0;
        rd_avail_d = 1'b0;
        wr_avail_d = 1'b0;
        for (int i = 0; i < ReadSlots; i++) begin
            release_d[0] = release_d[0] |
                           (slot_done(rd_state_d[i], rd_cnt_d[i]) ? (NumIds'(1) << rd_id_d[i]) : NumIds'(0));
            rd_avail_d   = rd_avail_d | (rd_state_d[i] == SLOT_FREE);
        end
        for (int i = 0; i < WriteSlots; i++) begin
            release_d[1] = release_d[1] |
                           (slot_done(wr_state_d[i], wr_cnt_d[i]) ? (NumIds'(1) << wr_id_d[i]) : NumIds'(0));
            wr_avail_d   = wr_avail_d | (wr_state_d[i] == SLOT_FREE);
        end
        error_d = error_q | rd_err_s | wr_err_s | wr_gate_err_s;
    end

    // Slot registers for both pools plus the registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ReadSlots; i++) begin
                rd_state_q[i] <= SLOT_FREE;
                rd_id_q[i]    <= '0;
                rd_cnt_q[i]   <= '0;
                rd_beats_q[i] <= '0;
            end
            for (int i = 0; i < WriteSlots; i++) begin
                wr_state_q[i] <= SLOT_FREE;
                wr_id_q[i]    <= '0;
                wr_cnt_q[i]   <= '0;
            end
            release_q  <= '0;
            rd_avail_q <= 1'b1;
            wr_avail_q <= 1'b1;
            error_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_id_q    <= rd_id_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_beats_q <= rd_beats_d;
            wr_state_q <= wr_state_d;
            wr_id_q    <= wr_id_d;
            wr_cnt_q   <= wr_cnt_d;
            release_q  <= release_d;
            rd_avail_q <= rd_avail_d;
            wr_avail_q <= wr_avail_d;
            error_q    <= error_d;
        end
    end

    assign release_en_o    = release_q;
    assign rd_slot_avail_o = rd_avail_q;
    assign wr_slot_avail_o = wr_avail_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Self-checking bench for simmem_release_scheduler: vector table, rise scoreboard and corner-case sequences.
module tb_simmem_release_scheduler;
    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              rd_addr_valid_i = 1'b0, rd_addr_ready_i = 1'b0;
    logic [3:0]        rd_addr_id_i = 4'd0;
    logic [7:0]        rd_addr_len_i = 8'd0;
    logic              wr_addr_valid_i = 1'b0, wr_addr_ready_i = 1'b0;
    logic [3:0]        wr_addr_id_i = 4'd0;
    logic              wr_data_valid_i = 1'b0, wr_data_ready_i = 1'b0, wr_data_last_i = 1'b0;
    logic              rd_data_valid_i = 1'b0, rd_data_ready_i = 1'b0;
    logic [3:0]        rd_data_id_i = 4'd0;
    logic              wr_resp_valid_i = 1'b0, wr_resp_ready_i = 1'b0;
    logic [3:0]        wr_resp_id_i = 4'd0;
    logic [7:0]        rd_delay_i = 8'd0, wr_delay_i = 8'd0;
    logic              rd_slot_avail_o, wr_slot_avail_o, error_o;
    logic [1:0][15:0]  release_en_o;

    simmem_release_scheduler dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_addr_valid_i(rd_addr_valid_i), .rd_addr_ready_i(rd_addr_ready_i),
        .rd_addr_id_i(rd_addr_id_i), .rd_addr_len_i(rd_addr_len_i),
        .wr_addr_valid_i(wr_addr_valid_i), .wr_addr_ready_i(wr_addr_ready_i), .wr_addr_id_i(wr_addr_id_i),
        .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_i(wr_data_ready_i), .wr_data_last_i(wr_data_last_i),
        .rd_data_valid_i(rd_data_valid_i), .rd_data_ready_i(rd_data_ready_i), .rd_data_id_i(rd_data_id_i),
        .wr_resp_valid_i(wr_resp_valid_i), .wr_resp_ready_i(wr_resp_ready_i), .wr_resp_id_i(wr_resp_id_i),
        .rd_delay_i(rd_delay_i), .wr_delay_i(wr_delay_i),
        .rd_slot_avail_o(rd_slot_avail_o), .wr_slot_avail_o(wr_slot_avail_o),
        .release_en_o(release_en_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected release rising edges: channel, id and cycle.
    typedef struct { int ch; int id; int cyc; } rise_t;
    rise_t sb_q[$];
    rise_t mon_e;
    logic [1:0][15:0] prev_rel = '0;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 16; i++) begin
                    if (release_en_o[c][i] && !prev_rel[c][i]) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_rise unexpected ch=%0d id=%0d cycle=%0d", c, i, cyc);
                        end else begin
                            mon_e = sb_q.pop_front();
                            if (mon_e.ch != c || mon_e.id != i || mon_e.cyc != cyc) begin
                                errors++;
                                $display("FAIL sb_rise actual ch=%0d id=%0d cycle=%0d expected ch=%0d id=%0d cycle=%0d",
                                         c, i, cyc, mon_e.ch, mon_e.id, mon_e.cyc);
                            end
                        end
                    end
                end
            end
        end
        prev_rel = release_en_o;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic expect_rise(input int ch, input int id, input int at);
        rise_t e;
        e.ch = ch; e.id = id; e.cyc = at;
        sb_q.push_back(e);
    endtask

    task automatic rd_alloc(input int id, input int len, input int dly);
        rd_addr_valid_i = 1'b1; rd_addr_ready_i = 1'b1;
        rd_addr_id_i = 4'(id); rd_addr_len_i = 8'(len); rd_delay_i = 8'(dly);
        step(1);
        rd_addr_valid_i = 1'b0; rd_addr_ready_i = 1'b0;
    endtask

    task automatic rd_beat(input int id);
        rd_data_valid_i = 1'b1; rd_data_ready_i = 1'b1; rd_data_id_i = 4'(id);
        step(1);
        rd_data_valid_i = 1'b0; rd_data_ready_i = 1'b0;
    endtask

    task automatic wr_alloc(input int id, input int dly, input bit last);
        wr_addr_valid_i = 1'b1; wr_addr_ready_i = 1'b1;
        wr_addr_id_i = 4'(id); wr_delay_i = 8'(dly);
        wr_data_valid_i = last; wr_data_ready_i = last; wr_data_last_i = last;
        step(1);
        wr_addr_valid_i = 1'b0; wr_addr_ready_i = 1'b0;
        wr_data_valid_i = 1'b0; wr_data_ready_i = 1'b0; wr_data_last_i = 1'b0;
    endtask

    task automatic wr_last();
        wr_data_valid_i = 1'b1; wr_data_ready_i = 1'b1; wr_data_last_i = 1'b1;
        step(1);
        wr_data_valid_i = 1'b0; wr_data_ready_i = 1'b0; wr_data_last_i = 1'b0;
    endtask

    task automatic wr_resp(input int id);
        wr_resp_valid_i = 1'b1; wr_resp_ready_i = 1'b1; wr_resp_id_i = 4'(id);
        step(1);
        wr_resp_valid_i = 1'b0; wr_resp_ready_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_release"}, 64'(release_en_o), 64'd0);
        chk({tag, "_rd_avail"}, 64'(rd_slot_avail_o), 64'd1);
        chk({tag, "_wr_avail"}, 64'(wr_slot_avail_o), 64'd1);
        chk({tag, "_error"}, 64'(error_o), 64'd0);
    endtask

    typedef struct { bit wr; int id; int len; int dly; int lat; } vec_t;
    vec_t vecs[7];

    initial begin
        int t0;
        int ch;
        vecs[0] = '{wr: 1'b0, id: 3,  len: 0,   dly: 5,   lat: 6};
        vecs[1] = '{wr: 1'b0, id: 7,  len: 3,   dly: 0,   lat: 1};
        vecs[2] = '{wr: 1'b1, id: 2,  len: 0,   dly: 0,   lat: 1};
        vecs[3] = '{wr: 1'b1, id: 15, len: 0,   dly: 9,   lat: 10};
        vecs[4] = '{wr: 1'b0, id: 0,  len: 255, dly: 1,   lat: 2};
        vecs[5] = '{wr: 1'b1, id: 9,  len: 0,   dly: 255, lat: 256};
        vecs[6] = '{wr: 1'b0, id: 12, len: 1,   dly: 2,   lat: 3};

        step(2);
        chk_reset_vals("reset");
        rst_ni = 1'b1;
        step(1);

        foreach (vecs[v]) begin
            ch = vecs[v].wr ? 1 : 0;
            t0 = cyc;
            expect_rise(ch, vecs[v].id, t0 + vecs[v].lat);
            if (vecs[v].wr) wr_alloc(vecs[v].id, vecs[v].dly, 1'b1);
            else rd_alloc(vecs[v].id, vecs[v].len, vecs[v].dly);
            if (vecs[v].lat > 1) begin
                step(vecs[v].lat - 2);
                chk("rel_early", 64'(release_en_o[ch][vecs[v].id]), 64'd0);
                step(1);
            end
            chk("rel_due", 64'(release_en_o[ch][vecs[v].id]), 64'd1);
            if (vecs[v].wr) begin
                wr_resp(vecs[v].id);
                chk("wr_rel_drop", 64'(release_en_o[1][vecs[v].id]), 64'd0);
                chk("wr_avail", 64'(wr_slot_avail_o), 64'd1);
            end else begin
                for (int b = 0; b <= vecs[v].len; b++) begin
                    rd_beat(vecs[v].id);
                    chk("rd_rel_beat", 64'(release_en_o[0][vecs[v].id]), (b == vecs[v].len) ? 64'd0 : 64'd1);
                end
                chk("rd_avail", 64'(rd_slot_avail_o), 64'd1);
            end
            chk("vec_error", 64'(error_o), 64'd0);
        end

        // Two reads with the same id keep the enable high across the first free.
        t0 = cyc;
        expect_rise(0, 1, t0 + 3);
        rd_alloc(1, 0, 2);
        rd_alloc(1, 0, 6);
        step(1);
        chk("dup_first", 64'(release_en_o[0][1]), 64'd1);
        step(5);
        chk("dup_both", 64'(release_en_o[0][1]), 64'd1);
        rd_beat(1);
        chk("dup_after1", 64'(release_en_o[0][1]), 64'd1);
        t0 = cyc;
        expect_rise(0, 6, t0 + 1);
        rd_data_valid_i = 1'b1; rd_data_ready_i = 1'b1; rd_data_id_i = 4'd1;
        rd_alloc(6, 0, 0);
        rd_data_valid_i = 1'b0; rd_data_ready_i = 1'b0;
        chk("dup_after2", 64'(release_en_o[0][1]), 64'd0);
        chk("alloc_free_same", 64'(release_en_o[0][6]), 64'd1);
        rd_beat(6);
        chk("alloc_free_drop", 64'(release_en_o[0][6]), 64'd0);
        chk("dup_error", 64'(error_o), 64'd0);

`ifdef SIMMEM_RELEASER_WDATA_GATE_EN
        // Countdown waits for the last beat; an early last beat becomes a credit.
        wr_alloc(4, 1, 1'b0);
        step(13);
        chk("gate_wait", 64'(release_en_o[1][4]), 64'd0);
        t0 = cyc;
        expect_rise(1, 4, t0 + 2);
        wr_last();
        step(1);
        chk("gate_due", 64'(release_en_o[1][4]), 64'd1);
        wr_resp(4);
        wr_last();
        step(2);
        t0 = cyc;
        expect_rise(1, 6, t0 + 1);
        wr_alloc(6, 0, 1'b0);
        chk("gate_credit", 64'(release_en_o[1][6]), 64'd1);
        wr_resp(6);
        chk("gate_error", 64'(error_o), 64'd0);
`endif

        // Write pool exhaustion: the ninth handshake is dropped and flags an error.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("wr_avail_7", 64'(wr_slot_avail_o), 64'd1);
            wr_alloc(i, 200, 1'b1);
        end
        chk("wr_full_avail", 64'(wr_slot_avail_o), 64'd0);
        chk("wr_full_noerr", 64'(error_o), 64'd0);
        chk("rd_indep_avail", 64'(rd_slot_avail_o), 64'd1);
        wr_alloc(8, 0, 1'b1);
        chk("wr_overflow_err", 64'(error_o), 64'd1);
        step(2);
        chk("wr_overflow_norel", 64'(release_en_o[1]), 64'd0);

        // Asynchronous reset mid-countdown with busy read slots.
        rd_alloc(2, 0, 100);
        rd_alloc(3, 0, 100);
        rd_alloc(4, 0, 100);
        #2 rst_ni = 1'b0;
        sb_q.delete();
        #1 chk_reset_vals("async_rst");
        step(2);
        rst_ni = 1'b1;
        step(1);
        t0 = cyc;
        expect_rise(0, 5, t0 + 1);
        rd_alloc(5, 0, 0);
        chk("post_rst_rel", 64'(release_en_o[0][5]), 64'd1);
        rd_beat(5);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("post_rst_avail_7", 64'(rd_slot_avail_o), 64'd1);
            rd_alloc(i, 0, 100);
        end
        chk("post_rst_full", 64'(rd_slot_avail_o), 64'd0);
        chk("post_rst_error", 64'(error_o), 64'd0);

        // Unmatched responses set the sticky error.
        rd_beat(9);
        chk("rd_unmatched", 64'(error_o), 64'd1);
        step(3);
        chk("err_sticky", 64'(error_o), 64'd1);
        rst_ni = 1'b0;
        sb_q.delete();
        step(2);
        rst_ni = 1'b1;
        step(1);
        chk("err_cleared", 64'(error_o), 64'd0);
        wr_resp(3);
        chk("wr_unmatched", 64'(error_o), 64'd1);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
